// File: rtl/crc_checker_pkg.sv
// crc_checker_pkg: FSM state encoding and default CRC constants shared by the
// checker and the generator path.
// Build option: CRC_CHK_HOLD_EN adds the WAIT state (verdict held until acked).
package crc_checker_pkg;

    localparam int unsigned CRC_DATA_WIDTH       = 32;
    localparam int unsigned CRC_HASH_LENGTH      = 64;
    localparam int unsigned CRC_INPUT_COUNT_BITS = 13;
    localparam int unsigned CRC_INPUT_COUNT      = 4158;
    localparam int unsigned CRC_PARITY_COUNT     = CRC_HASH_LENGTH / CRC_DATA_WIDTH;

    // CRC-64/ECMA-182 generator polynomial (x^64 term implicit); narrower
    // hash lengths use the low HASH_LENGTH bits.
    localparam logic [63:0] CRC_POLY64 = 64'h42F0_E1EB_A9EA_3693;

    // One-hot checker states.
`ifdef CRC_CHK_HOLD_EN
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_MSG     = 5'b00010,
        ST_PARITY  = 5'b00100,
        ST_VERDICT = 5'b01000,
        ST_WAIT    = 5'b10000
    } crc_chk_state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_MSG     = 4'b0010,
        ST_PARITY  = 4'b0100,
        ST_VERDICT = 4'b1000
    } crc_chk_state_t;
`endif

endpackage

// File: rtl/crc_checker_lfs_xor.sv
// CRC_parallel_m_lfs_XOR: combinational one-word CRC update. Folds DATA_WIDTH
// message bits, MSB first, into the running parity. Shared with the generator
// so both sides always use the same polynomial.
module CRC_parallel_m_lfs_XOR
    import crc_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = CRC_DATA_WIDTH,
    parameter int unsigned HASH_LENGTH = CRC_HASH_LENGTH
)(
    input  logic [DATA_WIDTH-1:0]  i_message,
    input  logic [HASH_LENGTH-1:0] i_cur_parity,
    output logic [HASH_LENGTH-1:0] o_next_parity
);

    localparam logic [HASH_LENGTH-1:0] POLY = HASH_LENGTH'(CRC_POLY64);

    // Unrolled bit-serial LFSR: one shift/conditional-XOR per message bit.
    always_comb begin
        logic [HASH_LENGTH-1:0] acc;
        logic                   fb;
        acc = i_cur_parity;
        fb  = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            fb  = acc[HASH_LENGTH-1] ^ i_message[DATA_WIDTH-1-i];
            acc = {acc[HASH_LENGTH-2:0], 1'b0};
            if (fb) begin
                acc = acc ^ POLY;
            end
        end
        o_next_parity = acc;
    end

endmodule

// File: rtl/crc_checker.sv
// crc_checker: streaming frame checker. Accepts INPUT_COUNT message words,
// computes their CRC, then compares PARITY_COUNT received parity words
// (MSB word first) against it and reports a one-cycle verdict.
// Build option: CRC_CHK_HOLD_EN adds i_verdict_ack; the verdict (complete=1)
// is then held in WAIT until acknowledged.
module crc_checker
    import crc_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = CRC_DATA_WIDTH,
    parameter int unsigned HASH_LENGTH      = CRC_HASH_LENGTH,
    parameter int unsigned INPUT_COUNT_BITS = CRC_INPUT_COUNT_BITS,
    parameter int unsigned INPUT_COUNT      = CRC_INPUT_COUNT,
    parameter int unsigned PARITY_COUNT     = CRC_PARITY_COUNT
)(
    input  logic                  i_clk,
    input  logic                  i_nRESET,
    input  logic                  i_execute_crc_chk,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
`ifdef CRC_CHK_HOLD_EN
    input  logic                  i_verdict_ack,
`endif
    output logic                  o_crc_chk_start,
    output logic                  o_last_message,
    output logic                  o_crc_chk_complete,
    output logic                  o_crc_error,
    output logic                  o_crc_available
);

    localparam logic [INPUT_COUNT_BITS-1:0] CNT_ONE      = INPUT_COUNT_BITS'(1);
    localparam logic [INPUT_COUNT_BITS-1:0] CNT_LAST_MSG = INPUT_COUNT_BITS'(INPUT_COUNT - 1);
    localparam logic [INPUT_COUNT_BITS-1:0] CNT_SAT      = INPUT_COUNT_BITS'(INPUT_COUNT);
    localparam logic [INPUT_COUNT_BITS-1:0] CNT_LAST_PAR = INPUT_COUNT_BITS'(PARITY_COUNT - 1);

    crc_chk_state_t              state_q, state_d;
    logic [INPUT_COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [HASH_LENGTH-1:0]      parity_q, parity_d;
    logic [HASH_LENGTH-1:0]      lfsr_seed, lfsr_next;
    logic                        err_acc_q, err_acc_d;
    logic                        err_q, err_d;
    logic                        start_c, last_c;
    logic [DATA_WIDTH-1:0]       par_expect;
    logic                        par_mismatch;

    // Top word of the computed parity is the one due next; the register is
    // shifted left after every parity word so the compare slice never moves.
    assign par_expect   = parity_q[HASH_LENGTH-1 -: DATA_WIDTH];
    assign par_mismatch = (i_data != par_expect);

    CRC_parallel_m_lfs_XOR #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HASH_LENGTH (HASH_LENGTH)
    ) u_parity_next (
        .i_message     (i_data),
        .i_cur_parity  (lfsr_seed),
        .o_next_parity (lfsr_next)
    );

    // State, counter, parity and error flag registers.
    always_ff @(posedge i_clk) begin
        if (!i_nRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            parity_q  <= '0;
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            parity_q  <= parity_d;
            err_acc_q <= err_acc_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath control; word acceptance is decided here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        parity_d  = parity_q;
        err_acc_d = err_acc_q;
        err_d     = err_q;
        lfsr_seed = parity_q;
        start_c   = 1'b0;
        last_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_execute_crc_chk && i_data_valid) begin
                    // First word is folded into a zero seed in the same cycle.
                    start_c   = 1'b1;
                    lfsr_seed = '0;
                    parity_d  = lfsr_next;
                    err_acc_d = 1'b0;
                    err_d     = 1'b0;
                    if (INPUT_COUNT == 1) begin
                        last_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_MSG;
                    end
                end
            end

            ST_MSG: begin
                if (i_data_valid) begin
                    parity_d = lfsr_next;
                    if (cnt_q == CNT_LAST_MSG) begin
                        last_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_PARITY: begin
                if (i_data_valid) begin
                    parity_d = parity_q << DATA_WIDTH;
                    if (par_mismatch) begin
                        err_acc_d = 1'b1;
                    end
                    if (cnt_q == CNT_LAST_PAR) begin
                        // Verdict includes a mismatch on this final word.
                        err_d   = err_acc_q | par_mismatch;
                        cnt_d   = '0;
                        state_d = ST_VERDICT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_VERDICT: begin
`ifdef CRC_CHK_HOLD_EN
                state_d = ST_WAIT;
`else
                state_d = ST_IDLE;
`endif
            end

`ifdef CRC_CHK_HOLD_EN
            ST_WAIT: begin
                if (i_verdict_ack) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; the pulses that depend on live inputs are masked in reset.
    always_comb begin
        o_crc_chk_start    = start_c & i_nRESET;
        o_last_message     = last_c & i_nRESET;
        o_crc_available    = (state_q == ST_IDLE);
`ifdef CRC_CHK_HOLD_EN
        o_crc_chk_complete = (state_q == ST_VERDICT) || (state_q == ST_WAIT);
`else
        o_crc_chk_complete = (state_q == ST_VERDICT);
`endif
        o_crc_error        = err_q;
    end

endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: directed self-checking bench for crc_checker (default build).
module tb_crc_checker;

    localparam int unsigned NMSG = 4158;
    localparam logic [63:0] POLY = 64'h42F0_E1EB_A9EA_3693;

    logic        clk = 1'b0;
    logic        nreset;
    logic        exec_chk;
    logic        data_valid;
    logic [31:0] data;
    logic        chk_start, last_message, chk_complete, crc_error, crc_available;
`ifdef CRC_CHK_HOLD_EN
    logic        verdict_ack = 1'b1;
`endif

    logic [31:0] msg [NMSG];

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    int unsigned cyc = 0;
    int unsigned n_start = 0, n_last = 0, n_cmp = 0, n_busy = 0;
    int unsigned n_start_in_verdict = 0;
    int unsigned cmp_cyc = 0, last_par_cyc = 0;
    logic        cmp_err = 1'bx;
    logic        err_after_start = 1'bx;
    logic        prev_start = 1'b0;

    crc_checker dut (
        .i_clk              (clk),
        .i_nRESET           (nreset),
        .i_execute_crc_chk  (exec_chk),
        .i_data_valid       (data_valid),
        .i_data             (data),
`ifdef CRC_CHK_HOLD_EN
        .i_verdict_ack      (verdict_ack),
`endif
        .o_crc_chk_start    (chk_start),
        .o_last_message     (last_message),
        .o_crc_chk_complete (chk_complete),
        .o_crc_error        (crc_error),
        .o_crc_available    (crc_available)
    );

    always #5 clk = ~clk;

    // Event recorder, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_start === 1'b1) err_after_start = crc_error;
        prev_start = chk_start;
        if (chk_start === 1'b1) n_start++;
        if (last_message === 1'b1) n_last++;
        if (crc_available === 1'b0) n_busy++;
        if (chk_start === 1'b1 && chk_complete === 1'b1) n_start_in_verdict++;
        if (chk_complete === 1'b1) begin
            n_cmp++;
            cmp_cyc = cyc;
            cmp_err = crc_error;
        end
    end

    // Reference CRC: augmented-message long division over the whole frame.
    function automatic logic [63:0] model_parity();
        logic [63:0] r;
        logic        top;
        r = '0;
        for (int w = 0; w < NMSG; w++) begin
            for (int b = 31; b >= 0; b--) begin
                top = r[63];
                r   = {r[62:0], msg[w][b]};
                if (top) r = r ^ POLY;
            end
        end
        for (int b = 0; b < 64; b++) begin
            top = r[63];
            r   = {r[62:0], 1'b0};
            if (top) r = r ^ POLY;
        end
        return r;
    endfunction

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input logic v, input logic e, input logic [31:0] d);
        data_valid = v;
        exec_chk   = e;
        data       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic send_frame(input logic [63:0] par, input bit gaps);
        step(1'b1, 1'b1, msg[0]);
        if (gaps) idle(3);
        for (int i = 1; i < NMSG; i++) begin
            step(1'b1, 1'b0, msg[i]);
            if (gaps && (i == 2000 || i == NMSG - 1)) idle(3);
        end
        step(1'b1, 1'b0, par[63:32]);
        if (gaps) idle(3);
        step(1'b1, 1'b0, par[31:0]);
        last_par_cyc = cyc;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hFFFF_FFFF);
        total_cnt++; if (crc_available !== 1'b1) $display("FAIL reset_available: got %b expected 1", crc_available); else pass_cnt++;
        total_cnt++; if (chk_start !== 1'b0) $display("FAIL reset_start: got %b expected 0", chk_start); else pass_cnt++;
        total_cnt++; if (last_message !== 1'b0) $display("FAIL reset_last: got %b expected 0", last_message); else pass_cnt++;
        total_cnt++; if (chk_complete !== 1'b0) $display("FAIL reset_complete: got %b expected 0", chk_complete); else pass_cnt++;
        total_cnt++; if (crc_error !== 1'b0) $display("FAIL reset_error: got %b expected 0", crc_error); else pass_cnt++;
        nreset = 1'b1;
        idle(2);
        total_cnt++; if (crc_available !== 1'b1) $display("FAIL idle_available: got %b expected 1", crc_available); else pass_cnt++;
        total_cnt++; if (n_start !== 0) $display("FAIL reset_no_start: got %0d expected 0", n_start); else pass_cnt++;
    endtask

    task automatic test_zero_frame();
        int unsigned c0, b0, s0, l0;
        for (int i = 0; i < NMSG; i++) msg[i] = 32'h0;
        c0 = n_cmp; b0 = n_busy; s0 = n_start; l0 = n_last;
        send_frame(64'h0, 1'b0);
        idle(2);
        total_cnt++; if (n_cmp - c0 !== 1) $display("FAIL zero_complete_count: got %0d expected 1", n_cmp - c0); else pass_cnt++;
        total_cnt++; if (cmp_cyc !== last_par_cyc + 1) $display("FAIL zero_latency: got cycle %0d expected %0d", cmp_cyc, last_par_cyc + 1); else pass_cnt++;
        total_cnt++; if (cmp_err !== 1'b0) $display("FAIL zero_error: got %b expected 0", cmp_err); else pass_cnt++;
        total_cnt++; if (n_busy - b0 !== 4160) $display("FAIL zero_busy_cycles: got %0d expected 4160", n_busy - b0); else pass_cnt++;
        total_cnt++; if (n_start - s0 !== 1) $display("FAIL zero_start_count: got %0d expected 1", n_start - s0); else pass_cnt++;
        total_cnt++; if (n_last - l0 !== 1) $display("FAIL zero_last_count: got %0d expected 1", n_last - l0); else pass_cnt++;
        total_cnt++; if (crc_available !== 1'b1) $display("FAIL zero_available_after: got %b expected 1", crc_available); else pass_cnt++;
    endtask

    task automatic test_good_frame(output logic [63:0] p);
        int unsigned c0;
        for (int i = 0; i < NMSG; i++) msg[i] = $urandom;
        p  = model_parity();
        c0 = n_cmp;
        send_frame(p, 1'b0);
        idle(2);
        total_cnt++; if (n_cmp - c0 !== 1) $display("FAIL good_complete_count: got %0d expected 1", n_cmp - c0); else pass_cnt++;
        total_cnt++; if (cmp_err !== 1'b0) $display("FAIL good_error: got %b expected 0", cmp_err); else pass_cnt++;
        msg[100] = msg[100] ^ 32'h0000_0020;
        send_frame(p, 1'b0);
        idle(2);
        total_cnt++; if (cmp_err !== 1'b1) $display("FAIL flipped_bit_error: got %b expected 1", cmp_err); else pass_cnt++;
        idle(3);
        total_cnt++; if (crc_error !== 1'b1) $display("FAIL error_hold: got %b expected 1", crc_error); else pass_cnt++;
        msg[100] = msg[100] ^ 32'h0000_0020;
    endtask

    task automatic test_last_word_error(input logic [63:0] p);
        send_frame(p ^ 64'h0000_0000_8000_0000, 1'b0);
        idle(2);
        total_cnt++; if (cmp_err !== 1'b1) $display("FAIL last_word_error: got %b expected 1", cmp_err); else pass_cnt++;
        total_cnt++; if (cmp_cyc !== last_par_cyc + 1) $display("FAIL last_word_latency: got cycle %0d expected %0d", cmp_cyc, last_par_cyc + 1); else pass_cnt++;
    endtask

    task automatic test_gaps(input logic [63:0] p);
        int unsigned c0, s0, l0;
        c0 = n_cmp; s0 = n_start; l0 = n_last;
        send_frame(p, 1'b1);
        idle(2);
        total_cnt++; if (cmp_err !== 1'b0) $display("FAIL gaps_error: got %b expected 0", cmp_err); else pass_cnt++;
        total_cnt++; if (n_cmp - c0 !== 1) $display("FAIL gaps_complete_count: got %0d expected 1", n_cmp - c0); else pass_cnt++;
        total_cnt++; if (n_start - s0 !== 1) $display("FAIL gaps_start_count: got %0d expected 1", n_start - s0); else pass_cnt++;
        total_cnt++; if (n_last - l0 !== 1) $display("FAIL gaps_last_count: got %0d expected 1", n_last - l0); else pass_cnt++;
        total_cnt++; if (cmp_cyc !== last_par_cyc + 1) $display("FAIL gaps_latency: got cycle %0d expected %0d", cmp_cyc, last_par_cyc + 1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int unsigned c0;
        for (int i = 0; i < NMSG; i++) msg[i] = 32'h0;
        c0 = n_cmp;
        step(1'b1, 1'b1, 32'h0);
        for (int i = 1; i <= 1000; i++) step(1'b1, 1'b0, 32'h0);
        nreset = 1'b0;
        idle(2);
        nreset = 1'b1;
        idle(5);
        total_cnt++; if (n_cmp !== c0) $display("FAIL abort_no_complete: got %0d pulses expected 0", n_cmp - c0); else pass_cnt++;
        total_cnt++; if (crc_available !== 1'b1) $display("FAIL abort_available: got %b expected 1", crc_available); else pass_cnt++;
        send_frame(64'h0, 1'b0);
        idle(2);
        total_cnt++; if (n_cmp - c0 !== 1) $display("FAIL after_abort_complete_count: got %0d expected 1", n_cmp - c0); else pass_cnt++;
        total_cnt++; if (cmp_err !== 1'b0) $display("FAIL after_abort_error: got %b expected 0", cmp_err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int unsigned c0, s0, v0, first_par;
        for (int i = 0; i < NMSG; i++) msg[i] = 32'h0;
        c0 = n_cmp; s0 = n_start; v0 = n_start_in_verdict;
        send_frame(64'h0000_0000_0000_0001, 1'b0);
        first_par = last_par_cyc;
        // VERDICT cycle: this execute + word must be ignored.
        step(1'b1, 1'b1, 32'hDEAD_BEEF);
        total_cnt++; if (cmp_err !== 1'b1) $display("FAIL b2b_first_error: got %b expected 1", cmp_err); else pass_cnt++;
        total_cnt++; if (cmp_cyc !== first_par + 1) $display("FAIL b2b_first_latency: got cycle %0d expected %0d", cmp_cyc, first_par + 1); else pass_cnt++;
        err_after_start = 1'bx;
        send_frame(64'h0, 1'b0);
        idle(2);
        total_cnt++; if (err_after_start !== 1'b0) $display("FAIL b2b_error_clear_on_start: got %b expected 0", err_after_start); else pass_cnt++;
        total_cnt++; if (n_start_in_verdict !== v0) $display("FAIL b2b_start_in_verdict: got %0d expected 0", n_start_in_verdict - v0); else pass_cnt++;
        total_cnt++; if (n_start - s0 !== 2) $display("FAIL b2b_start_count: got %0d expected 2", n_start - s0); else pass_cnt++;
        total_cnt++; if (n_cmp - c0 !== 2) $display("FAIL b2b_complete_count: got %0d expected 2", n_cmp - c0); else pass_cnt++;
        total_cnt++; if (cmp_err !== 1'b0) $display("FAIL b2b_second_error: got %b expected 0", cmp_err); else pass_cnt++;
    endtask

    initial begin
        logic [63:0] good_p;
        nreset     = 1'b0;
        exec_chk   = 1'b0;
        data_valid = 1'b0;
        data       = 32'h0;
        test_reset();
        test_zero_frame();
        test_good_frame(good_p);
        test_last_word_error(good_p);
        test_gaps(good_p);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
